// File: rtl/serial_alu_ctrl_if.sv
// Bundle between a requester, the serial ALU sequencer and the external 1-bit ALU slice.
// Optional overflow signal present only when OVERFLOW_FLAG_EN is defined.
interface serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  // Request / result side
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryOut;
`ifdef OVERFLOW_FLAG_EN
  logic             overflow;
`endif

  // Slice side
  logic aluA;
  logic aluB;
  logic aluC0;
  logic aluC1;
  logic aluCarryIn;
  logic aluY;
  logic aluZ;

  // Requester; also closes the loop through the slice
  modport master (
    output start, op, opA, opB,
    input  busy, done, result, carryOut,
`ifdef OVERFLOW_FLAG_EN
    input  overflow,
`endif
    input  aluA, aluB, aluC0, aluC1, aluCarryIn,
    output aluY, aluZ
  );

  // Sequencer
  modport slave (
    input  start, op, opA, opB,
    output busy, done, result, carryOut,
`ifdef OVERFLOW_FLAG_EN
    output overflow,
`endif
    output aluA, aluB, aluC0, aluC1, aluCarryIn,
    input  aluY, aluZ
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for an external combinational 1-bit ALU slice. Streams two WIDTH-bit
// operands LSB first, chains the carry through a register and assembles the result.
// Optional feature: define OVERFLOW_FLAG_EN to add a signed-overflow flag for ADD/SUB.
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  serial_alu_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;
  localparam logic [1:0] OpSub = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    count_q;

  logic is_sub;
  logic is_arith;

  assign is_sub   = (op_q == OpSub);
  assign is_arith = op_q[1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slice drive; slice inputs are held at 0 outside RUN
  always_comb begin
    state_d        = state_q;
    bus.aluA       = 1'b0;
    bus.aluB       = 1'b0;
    bus.aluC0      = 1'b0;
    bus.aluC1      = 1'b0;
    bus.aluCarryIn = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        bus.aluA = a_q[0];
        bus.aluB = b_q[0] ^ is_sub;
        // SUB runs on the slice as ADD of the inverted operand with carry-in 1
        {bus.aluC1, bus.aluC0} = is_sub ? OpAdd : op_q;
        bus.aluCarryIn = is_arith ? carry_q : 1'b0;
        if (count_q == LastIdx) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Operand shifting, carry chaining and result assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OpAnd;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.opA;
            b_q     <= bus.opB;
            count_q <= '0;
            carry_q <= (bus.op == OpSub);
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {bus.aluY, res_q[WIDTH-1:1]};
          if (is_arith) carry_q <= bus.aluZ;
          if (count_q == LastIdx) begin
            cout_q <= is_arith ? bus.aluZ : 1'b0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;

  // Overflow: carry into MSB differs from carry out of MSB
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && count_q == LastIdx) begin
      ovf_q <= is_arith ? (carry_q ^ bus.aluZ) : 1'b0;
    end
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.result   = res_q;
  assign bus.carryOut = cout_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed testbench for serial_alu_ctrl with a behavioural 1-bit ALU slice in the loop.
// Overflow checks are compiled in when OVERFLOW_FLAG_EN is defined.
module tb_serial_alu_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  serial_alu_ctrl_if #(.WIDTH(8)) bus ();

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: 00 AND, 01 OR, 1x full add
  always_comb begin
    unique case ({bus.aluC1, bus.aluC0})
      2'b00:   bus.aluY = bus.aluA & bus.aluB;
      2'b01:   bus.aluY = bus.aluA | bus.aluB;
      default: bus.aluY = bus.aluA ^ bus.aluB ^ bus.aluCarryIn;
    endcase
    bus.aluZ = (bus.aluA & bus.aluB) | (bus.aluA & bus.aluCarryIn) | (bus.aluB & bus.aluCarryIn);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_outs();
    return 32'({bus.aluA, bus.aluB, bus.aluC0, bus.aluC1, bus.aluCarryIn});
  endfunction

  // Called at a negedge in IDLE; starts immediately so consecutive calls run back-to-back.
  // glitch_at != 0 pulses start with other operands in that RUN cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res, input logic exp_cout,
                        input logic exp_ovf, input int glitch_at);
    int   lat;
    bit   seen;
    logic sub;
    sub       = (op == 2'b11);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    lat       = 0;
    seen      = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      if (lat == 1) begin
        check_eq({tag, " busy"}, 32'(bus.busy), 32'd1);
        check_eq({tag, " c1c0"}, 32'({bus.aluC1, bus.aluC0}), sub ? 32'd2 : 32'(op));
        check_eq({tag, " cin0"}, 32'(bus.aluCarryIn), 32'(sub));
        check_eq({tag, " a0"}, 32'(bus.aluA), 32'(a[0]));
        check_eq({tag, " b0"}, 32'(bus.aluB), 32'(b[0] ^ sub));
      end
      if (glitch_at != 0 && lat == glitch_at) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.opA   = ~a;
        bus.opB   = ~b;
      end
      if (bus.done) seen = 1'b1;
    end
    check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'd9);
    check_eq({tag, " result"}, 32'(bus.result), 32'(exp_res));
    check_eq({tag, " carryOut"}, 32'(bus.carryOut), 32'(exp_cout));
`ifdef OVERFLOW_FLAG_EN
    check_eq({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unused overflow expectation");
`endif
    check_eq({tag, " busy_done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " alu_done"}, alu_outs(), 32'd0);
    @(negedge clk);
    check_eq({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    check_eq({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " result_hold"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    int lat;
    bit stray;
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opA   = 8'h00;
    bus.opB   = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst busy", 32'(bus.busy), 32'd0);
    check_eq("rst done", 32'(bus.done), 32'd0);
    check_eq("rst result", 32'(bus.result), 32'd0);
    check_eq("rst carryOut", 32'(bus.carryOut), 32'd0);
    check_eq("rst alu", alu_outs(), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check_eq("rst overflow", 32'(bus.overflow), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    run_op("add 3c+0f", 2'b10, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 0);
    run_op("add ff+01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
    run_op("sub 05-07", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0);
    run_op("sub 07-05", 2'b11, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 0);
    run_op("and f0,3c", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0);
    run_op("or f0,0c", 2'b01, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 0);
    run_op("and ff,80", 2'b00, 8'hFF, 8'h80, 8'h80, 1'b0, 1'b0, 0);
    run_op("add 7f+01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
    run_op("glitch add", 2'b10, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 3);

    // Reset in RUN cycle 4 aborts the run without a done
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opA   = 8'hFF;
    bus.opB   = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check_eq("pre-reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort busy", 32'(bus.busy), 32'd0);
    check_eq("abort done", 32'(bus.done), 32'd0);
    check_eq("abort result", 32'(bus.result), 32'd0);
    check_eq("abort carryOut", 32'(bus.carryOut), 32'd0);
    check_eq("abort alu", alu_outs(), 32'd0);
    stray = 1'b0;
    for (lat = 0; lat < 12; lat++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray = 1'b1;
    end
    check_eq("abort no_done", 32'(stray), 32'd0);

    run_op("after reset", 2'b11, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
